// File: rtl/add_round_key_col.sv
// Column-serial AES AddRoundKey: XORs four 32-bit mixed columns with the round key
// and assembles them into a 128-bit state behind a one-entry output register.
// Optional byte parity output enabled by defining ARK_PARITY_EN.
module add_round_key_col #(
   parameter int unsigned NCOL = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic [31:0]          col_in,
   input  logic                 col_valid,
   output logic                 col_ready,
   input  logic [32*NCOL-1:0]   key_in,
   output logic [32*NCOL-1:0]   state_out,
   output logic                 state_valid,
`ifdef ARK_PARITY_EN
   output logic [4*NCOL-1:0]    state_par,
`endif
   input  logic                 state_ready
);

   localparam int unsigned SW = 32 * NCOL;

   typedef enum logic [2:0] {
      C0   = 3'd0,
      C1   = 3'd1,
      C2   = 3'd2,
      C3   = 3'd3,
      FULL = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [SW-1:0]   r_key;
   logic [SW-1:0]   r_asm;
   logic [SW-1:0]   r_state_out;
   logic            r_state_valid;

   logic            w_accept;
   logic            w_out_free;
   logic            w_load_out;
   logic [31:0]     w_key_word;
   logic [31:0]     w_keyed;
   logic [SW-1:0]   w_load_data;

   assign w_accept   = col_valid && (r_state != FULL);
   assign w_out_free = !r_state_valid || state_ready;
   assign w_keyed    = col_in ^ w_key_word;

   // Column 0 keys against key_in directly since r_key is only captured on that edge.
   always_comb begin
      w_key_word = '0;
      unique case (r_state)
         C0:      w_key_word = key_in[127:96];
         C1:      w_key_word = r_key[95:64];
         C2:      w_key_word = r_key[63:32];
         C3:      w_key_word = r_key[31:0];
         default: w_key_word = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C0;
      end else if (clr) begin
         r_state <= C0;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         C0:      if (w_accept) w_next = C1;
         C1:      if (w_accept) w_next = C2;
         C2:      if (w_accept) w_next = C3;
         C3:      if (w_accept) w_next = w_out_free ? C0 : FULL;
         FULL:    if (w_out_free) w_next = C0;
         default: w_next = C0;
      endcase
   end

   always_comb begin
      w_load_out  = 1'b0;
      w_load_data = '0;
      if (r_state == FULL) begin
         w_load_out  = w_out_free;
         w_load_data = r_asm;
      end else if (r_state == C3) begin
         w_load_out  = w_accept && w_out_free;
         w_load_data = {r_asm[127:32], w_keyed};
      end
   end

   assign col_ready = (r_state != FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key <= '0;
         r_asm <= '0;
      end else if (clr) begin
         r_key <= '0;
         r_asm <= '0;
      end else if (w_accept) begin
         unique case (r_state)
            C0: begin
               r_key          <= key_in;
               r_asm[127:96]  <= w_keyed;
            end
            C1:      r_asm[95:64] <= w_keyed;
            C2:      r_asm[63:32] <= w_keyed;
            C3:      r_asm[31:0]  <= w_keyed;
            default: r_asm        <= r_asm;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_out   <= '0;
         r_state_valid <= 1'b0;
      end else if (clr) begin
         r_state_out   <= '0;
         r_state_valid <= 1'b0;
      end else if (w_load_out) begin
         r_state_out   <= w_load_data;
         r_state_valid <= 1'b1;
      end else if (state_ready) begin
         r_state_valid <= 1'b0;
      end
   end

   assign state_out   = r_state_out;
   assign state_valid = r_state_valid;

`ifdef ARK_PARITY_EN
   logic [4*NCOL-1:0] r_par;
   logic [4*NCOL-1:0] w_par;

   always_comb begin
      w_par = '0;
      for (int unsigned j = 0; j < 4 * NCOL; j++) begin
         w_par[4*NCOL-1-j] = ^w_load_data[SW-1-8*j -: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par <= '0;
      end else if (clr) begin
         r_par <= '0;
      end else if (w_load_out) begin
         r_par <= w_par;
      end
   end

   assign state_par = r_par;
`endif

endmodule

// File: tb/tb_add_round_key_col.sv
// Directed self-checking bench for add_round_key_col; inputs change and outputs
// are sampled on the falling clock edge.
module tb_add_round_key_col;

   logic         clk;
   logic         rst_n;
   logic         clr;
   logic [31:0]  col_in;
   logic         col_valid;
   logic         col_ready;
   logic [127:0] key_in;
   logic [127:0] state_out;
   logic         state_valid;
   logic         state_ready;
`ifdef ARK_PARITY_EN
   logic [15:0]  state_par;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] FIPS_KEY = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
   localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2_689f352b_6b5bea43_026a5049;
   localparam logic [127:0] FIPS_COL = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

   add_round_key_col #(.NCOL(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .col_in      (col_in),
      .col_valid   (col_valid),
      .col_ready   (col_ready),
      .key_in      (key_in),
      .state_out   (state_out),
      .state_valid (state_valid),
`ifdef ARK_PARITY_EN
      .state_par   (state_par),
`endif
      .state_ready (state_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents one column for a single edge, then leaves col_valid low.
   task automatic send_col(input logic [31:0] c);
      col_in    = c;
      col_valid = 1'b1;
      @(negedge clk);
      col_valid = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] cols);
      logic [127:0] tmp;
      tmp = cols;
      for (int i = 0; i < 4; i++) begin
         col_in    = tmp[127-32*i -: 32];
         col_valid = 1'b1;
         @(negedge clk);
      end
      col_valid = 1'b0;
   endtask

   initial begin
      logic [127:0] blk_p;
      logic [127:0] blk_q;
      logic [127:0] blk;
      int pulses;
      int drops;

      rst_n = 1'b0; clr = 1'b0; col_in = '0; col_valid = 1'b0;
      key_in = '0; state_ready = 1'b0;
      #12;
      check("reset_out",   state_out,   '0);
      check("reset_valid", {127'd0, state_valid}, 128'd0);
      check("reset_ready", {127'd0, col_ready},   128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // FIPS-197 round 1 AddRoundKey
      state_ready = 1'b1;
      key_in = FIPS_KEY;
      send_col(FIPS_COL[127:96]);
      send_col(FIPS_COL[95:64]);
      send_col(FIPS_COL[63:32]);
      check("fips_valid_early", {127'd0, state_valid}, 128'd0);
      send_col(FIPS_COL[31:0]);
      check("fips_valid", {127'd0, state_valid}, 128'd1);
      check("fips_out",   state_out, FIPS_OUT);
      @(negedge clk);
      check("fips_drain", {127'd0, state_valid}, 128'd0);

      // key_in changed after column 0 must not affect the block
      key_in = FIPS_KEY;
      send_col(FIPS_COL[127:96]);
      key_in = '1;
      send_col(FIPS_COL[95:64]);
      send_col(FIPS_COL[63:32]);
      send_col(FIPS_COL[31:0]);
      check("keysamp_out", state_out, FIPS_OUT);
      key_in = '0;
      send_block(128'h11223344_55667788_99aabbcc_ddeeff00);
      check("key0_raw", state_out, 128'h11223344_55667788_99aabbcc_ddeeff00);
      @(negedge clk);

      // Backpressure: two blocks back to back, output stalled
      state_ready = 1'b0;
      blk_p = 128'h01010101_02020202_03030303_04040404;
      blk_q = 128'hf0f0f0f0_e1e1e1e1_d2d2d2d2_c3c3c3c3;
      send_block(blk_p);
      check("bp_p_valid", {127'd0, state_valid}, 128'd1);
      check("bp_p_out",   state_out, blk_p);
      send_block(blk_q);
      check("bp_full_ready", {127'd0, col_ready}, 128'd0);
      check("bp_p_hold",     state_out, blk_p);
      @(negedge clk);
      check("bp_p_hold2",    state_out, blk_p);
      state_ready = 1'b1;
      @(negedge clk);
      state_ready = 1'b0;
      check("bp_q_out",   state_out, blk_q);
      check("bp_q_valid", {127'd0, state_valid}, 128'd1);
      check("bp_ready_back", {127'd0, col_ready}, 128'd1);
      @(negedge clk);
      check("bp_q_hold", state_out, blk_q);
      state_ready = 1'b1;
      @(negedge clk);
      check("bp_q_drain", {127'd0, state_valid}, 128'd0);

      // Streaming: 16 columns with both handshakes held open
      pulses = 0;
      drops  = 0;
      for (int k = 0; k < 16; k++) begin
         col_in    = {8'ha0 + 8'(k / 4), 8'(k % 4), 16'h5a5a};
         col_valid = 1'b1;
         @(negedge clk);
         if (!col_ready) drops++;
         check("stream_valid", {127'd0, state_valid}, {127'd0, ((k % 4) == 3)});
         if (state_valid) begin
            pulses++;
            blk = {8'ha0 + 8'(k / 4), 8'd0, 16'h5a5a,
                   8'ha0 + 8'(k / 4), 8'd1, 16'h5a5a,
                   8'ha0 + 8'(k / 4), 8'd2, 16'h5a5a,
                   8'ha0 + 8'(k / 4), 8'd3, 16'h5a5a};
            check("stream_out", state_out, blk);
         end
      end
      col_valid = 1'b0;
      check("stream_pulses", 128'(pulses), 128'd4);
      check("stream_drops",  128'(drops),  128'd0);
      @(negedge clk);

      // clr mid-block, with a held output entry and a simultaneous column offer
      state_ready = 1'b0;
      send_block(128'hdeadbeef_deadbeef_deadbeef_deadbeef);
      send_col(32'h77777777);
      send_col(32'h88888888);
      clr = 1'b1; col_in = 32'h99999999; col_valid = 1'b1;
      @(negedge clk);
      clr = 1'b0; col_valid = 1'b0;
      check("clr_valid", {127'd0, state_valid}, 128'd0);
      check("clr_out",   state_out, '0);
      check("clr_ready", {127'd0, col_ready}, 128'd1);
      state_ready = 1'b1;
      send_block(128'hcafef00d_12345678_0badc0de_87654321);
      check("clr_post_out",   state_out, 128'hcafef00d_12345678_0badc0de_87654321);
      check("clr_post_valid", {127'd0, state_valid}, 128'd1);
      @(negedge clk);

      // Asynchronous reset mid-block
      state_ready = 1'b0;
      send_block(128'h13579bdf_2468ace0_fedcba98_76543210);
      send_col(32'haaaaaaaa);
      send_col(32'hbbbbbbbb);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out",   state_out, '0);
      check("arst_valid", {127'd0, state_valid}, 128'd0);
      check("arst_ready", {127'd0, col_ready},   128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      state_ready = 1'b1;
      send_block(128'h00000001_00000002_00000003_00000004);
      check("arst_post_out", state_out, 128'h00000001_00000002_00000003_00000004);
      @(negedge clk);

`ifdef ARK_PARITY_EN
      // Byte 0 = 01 has odd weight; byte 15 = ff has even weight, so its bit is 0.
      send_block(128'h01000000_00000000_00000000_000000ff);
      check("par_out", state_out, 128'h01000000_00000000_00000000_000000ff);
      check("par_bits", {112'd0, state_par}, {112'd0, 16'h8000});
      @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
